// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: big-endian length then data words into instruction BRAM, then core_run; stop->byte_valid 1 cycle, byte_valid->prog_we 1 cycle.
// No backpressure (RX cannot be stalled). Optional trailing checksum byte under UART_PROGRAM_LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [32:0]   MAX_LEN   = 33'(1) << ADDR_W;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd2;
`endif
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_vld;
  logic [7:0]    r_byte_dat;

  logic [2:0]        r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_word_idx;
  logic [ADDR_W-1:0] r_last_idx;
  logic              r_prog_we;
  logic [ADDR_W-1:0] r_prog_addr;
  logic [31:0]       r_prog_wdata;
  logic              r_core_run;
  logic              r_busy;
  logic              r_err;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_start_ok;
  logic        w_frame_err;
  logic        w_active;
  logic [31:0] w_word;

  assign w_start_ok  = (r_rx_state == RX_START) && (r_clk_cnt == HALF_LAST) && !r_rx_sync;
  assign w_frame_err = (r_rx_state == RX_STOP) && (r_clk_cnt == BIT_LAST) && !r_rx_sync;
  assign w_word      = {r_asm, r_byte_dat};
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  assign w_active = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_active = (r_state == S_LEN) || (r_state == S_DATA);
`endif

  // Receiver: start re-checked at mid-bit, then one sample per bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_byte_dat <= '0;
    end else begin
      r_rx_meta  <= rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_byte_vld <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_vld <= 1'b1;
              r_byte_dat <= r_shift;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_WAIT;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_LEN;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_word_idx   <= '0;
      r_last_idx   <= '0;
      r_prog_we    <= 1'b0;
      r_prog_addr  <= '0;
      r_prog_wdata <= '0;
      r_core_run   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_prog_we  <= 1'b0;
      r_core_run <= (r_state == S_DONE);
      if (w_start_ok && w_active) r_busy <= 1'b1;
      if (w_frame_err && w_active) r_err <= 1'b1;
      if (r_byte_vld) begin
        case (r_state)
          S_LEN: begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_asm      <= w_word[23:0];
            if (r_byte_cnt == 2'd3) begin
              if (w_word == 32'd0) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end else if ({1'b0, w_word} > MAX_LEN) begin
                r_state <= S_HALT;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_last_idx <= ADDR_W'(w_word - 32'd1);
                r_state    <= S_DATA;
              end
            end
          end
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_asm      <= w_word[23:0];
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum + r_byte_dat;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_prog_we    <= 1'b1;
              r_prog_addr  <= r_word_idx;
              r_prog_wdata <= w_word;
              r_word_idx   <= r_word_idx + 1'b1;
              if (r_word_idx == r_last_idx) begin
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_DONE;
                r_busy  <= 1'b0;
`endif
              end
            end
          end
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
          S_CSUM: begin
            r_busy <= 1'b0;
            if (r_byte_dat == r_csum) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_HALT;
              r_err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign prog_we    = r_prog_we;
  assign prog_addr  = r_prog_addr;
  assign prog_wdata = r_prog_wdata;
  assign core_run   = r_core_run;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
